// File: rtl/binary_to_twos_comp.sv
// Registered two's-complement negator with zero/most-negative flags and 1-cycle latency.
// Optional build macro BIN2SC_SATURATE_EN: saturate the most-negative input to the most positive value.
module binary_to_twos_comp #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] binary_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] twos_comp_out,
  output logic             is_zero,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             ovf;
  } resp_t;

  resp_t nxt, res_q;
  logic  vld_q;

  always_comb begin
    nxt      = '0;
    nxt.zero = (binary_in == '0);
    nxt.ovf  = (binary_in == MOST_NEG);
    nxt.data = ~binary_in + ONE;
`ifdef BIN2SC_SATURATE_EN
    // Negating the most negative value is unrepresentable; clamp instead of wrapping.
    if (nxt.ovf) nxt.data = MOST_POS;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      res_q <= '0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) res_q <= nxt;
    end
  end

  assign out_valid     = vld_q;
  assign twos_comp_out = res_q.data;
  assign is_zero       = res_q.zero;
  assign overflow      = res_q.ovf;

endmodule

// File: tb/tb_binary_to_twos_comp.sv
module tb_binary_to_twos_comp;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] binary_in = '0;
  logic         out_valid;
  logic [W-1:0] twos_comp_out;
  logic         is_zero, overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit     vld;
    longint d;
    bit     z;
    bit     o;
  } exp_t;

  exp_t sb[$];

  longint hd = 0;
  bit     hz = 0, ho = 0;

  binary_to_twos_comp #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .binary_in(binary_in),
    .out_valid(out_valid), .twos_comp_out(twos_comp_out),
    .is_zero(is_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic step(input bit r, input bit v, input longint x);
    longint m;
    exp_t   e;
    @(posedge clk);
    #1;
    rst = r; in_valid = v; binary_in = W'(x);
    m = longint'(1) << W;
    if (r) begin
      hd = 0; hz = 0; ho = 0;
      e.vld = 0;
    end else if (v) begin
      hz = (x == 0);
      ho = (x == m / 2);
      hd = (m - x) % m;
`ifdef BIN2SC_SATURATE_EN
      if (ho) hd = m / 2 - 1;
`endif
      e.vld = 1;
    end else begin
      e.vld = 0;
    end
    e.d = hd; e.z = hz; e.o = ho;
    sb.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() >= 2) begin
        e = sb.pop_front();
        checks++;
        if (out_valid !== e.vld || twos_comp_out !== W'(e.d) ||
            is_zero !== e.z || overflow !== e.o) begin
          errors++;
          $display("FAIL out t=%0t got v=%b d=%b z=%b o=%b exp v=%b d=%b z=%b o=%b",
                   $time, out_valid, twos_comp_out, is_zero, overflow,
                   e.vld, W'(e.d), e.z, e.o);
        end
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout t=%0t: simulation did not complete", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    step(1, 0, 0);
    step(1, 0, 0);
    checks++;
    if (out_valid !== 1'b0 || twos_comp_out !== '0 ||
        is_zero !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset t=%0t got v=%b d=%b z=%b o=%b",
               $time, out_valid, twos_comp_out, is_zero, overflow);
    end
    step(0, 1, 5);
    for (int i = 0; i < 8; i++) step(0, 1, i);
    step(0, 1, 0);
    step(0, 1, 4);
    step(0, 1, 1);
    step(0, 0, 0);
    step(0, 1, 6);
    step(0, 0, 0);
    step(0, 1, 2);
    step(1, 1, 3);
    step(0, 0, 0);
    step(0, 1, 3);
    step(0, 1, 4);
    step(0, 0, 0);
    for (int i = 0; i < 60; i++)
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
           longint'($urandom_range(0, (1 << W) - 1)));
    step(0, 0, 0);
    step(0, 0, 0);
    @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
